// File: rtl/ntt_pair_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : ntt_pair_scheduler
// Description : Issues one in-place radix-2 NTT butterfly address pair per
//               cycle (stage-major), with twiddle index, stage tag and a
//               start/busy/done handshake. Optional macro STAGE_GAP_EN
//               inserts STAGE_GAP idle cycles between consecutive stages.
// Revision    : 1.0 - initial release
// =============================================================================
module ntt_pair_scheduler #(
    parameter int LOGN      = 10,
    parameter int STAGE_W   = 4,
    parameter int STAGE_GAP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic               valid,
    output logic [LOGN-1:0]    old_address_0,
    output logic [LOGN-1:0]    old_address_1,
    output logic [LOGN-2:0]    twiddle_index,
    output logic [STAGE_W-1:0] stage,
    output logic               last,
    output logic               busy,
    output logic               done
);

    localparam logic [LOGN-2:0]    c_HALF_M1    = '1;
    localparam logic [LOGN-2:0]    c_ONE_J      = (LOGN-1)'(1);
    localparam logic [LOGN-1:0]    c_ONE_A      = LOGN'(1);
    localparam logic [STAGE_W-1:0] c_ONE_S      = STAGE_W'(1);
    localparam logic [STAGE_W-1:0] c_LAST_STAGE = STAGE_W'(LOGN - 1);

    generate
        if (STAGE_GAP < 1 || (1 << STAGE_W) <= LOGN || LOGN < 2) begin : g_bad_params
            $error("ntt_pair_scheduler: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [STAGE_W-1:0]   r_s;
    logic [LOGN-2:0]      r_j;
    logic                 r_valid;
    logic [LOGN-1:0]      r_a0;
    logic [LOGN-1:0]      r_a1;
    logic [LOGN-2:0]      r_tw;
    logic [STAGE_W-1:0]   r_stage;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_done;

`ifdef STAGE_GAP_EN
    localparam int              c_GAP_W      = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_RELOAD = c_GAP_W'(STAGE_GAP - 1);
    logic [c_GAP_W-1:0]         r_gap_cnt;
`endif

    // Butterfly j of stage s: lo selects the offset inside a block of 2^(s+1)
    // points, hi selects the block; the partner differs only in bit s.
    logic [LOGN-2:0] w_mask;
    logic [LOGN-2:0] w_lo;
    logic [LOGN-2:0] w_hi;
    logic [LOGN-1:0] w_a0;
    logic [LOGN-1:0] w_a1;
    logic [LOGN-2:0] w_tw;
    logic            w_j_end;
    logic            w_s_end;

    assign w_mask  = (c_ONE_J << r_s) - c_ONE_J;
    assign w_lo    = r_j & w_mask;
    assign w_hi    = r_j >> r_s;
    assign w_a0    = ({1'b0, w_hi} << (r_s + c_ONE_S)) | {1'b0, w_lo};
    assign w_a1    = w_a0 | (c_ONE_A << r_s);
    assign w_tw    = w_lo << (c_LAST_STAGE - r_s);
    assign w_j_end = (r_j == c_HALF_M1);
    assign w_s_end = (r_s == c_LAST_STAGE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_valid <= 1'b0;
            r_a0    <= '0;
            r_a1    <= '0;
            r_tw    <= '0;
            r_stage <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef STAGE_GAP_EN
            r_gap_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= start;
                    if (start) begin
                        r_state <= S_RUN;
                        r_s     <= '0;
                        r_j     <= '0;
                    end
                end
                S_RUN: begin
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    if (stall) begin
                        // Pair outputs keep their last values; only valid drops.
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                        r_a0    <= w_a0;
                        r_a1    <= w_a1;
                        r_tw    <= w_tw;
                        r_stage <= r_s;
                        r_last  <= w_j_end;
                        if (!w_j_end) begin
                            r_j <= r_j + c_ONE_J;
                        end else begin
                            r_j <= '0;
                            if (w_s_end) begin
                                r_state <= S_DONE;
                            end else begin
                                r_s <= r_s + c_ONE_S;
`ifdef STAGE_GAP_EN
                                r_state   <= S_GAP;
                                r_gap_cnt <= c_GAP_RELOAD;
`endif
                            end
                        end
                    end
                end
`ifdef STAGE_GAP_EN
                S_GAP: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    if (r_gap_cnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign valid         = r_valid;
    assign old_address_0 = r_a0;
    assign old_address_1 = r_a1;
    assign twiddle_index = r_tw;
    assign stage         = r_stage;
    assign last          = r_last;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ntt_pair_scheduler.sv
`default_nettype none
// =============================================================================
// Module      : tb_ntt_pair_scheduler
// Description : Randomized self-checking bench; expected pairs come from a
//               block/offset model of the radix-2 NTT schedule.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_ntt_pair_scheduler;

`ifdef STAGE_GAP_EN
    localparam int LOGN      = 4;
    localparam int STAGE_W   = 3;
    localparam int STAGE_GAP = 4;
    localparam int GAP_PER   = STAGE_GAP;
    localparam bit GAP_BUILD = 1'b1;
`else
    localparam int LOGN      = 10;
    localparam int STAGE_W   = 4;
    localparam int STAGE_GAP = 4;
    localparam int GAP_PER   = 0;
    localparam bit GAP_BUILD = 1'b0;
`endif
    localparam int N           = 1 << LOGN;
    localparam int HALF        = N / 2;
    localparam int TOTAL       = LOGN * HALF;
    localparam int GAPS        = (LOGN - 1) * GAP_PER;
    localparam int ABORT_STAGE = (LOGN > 5) ? 5 : LOGN / 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stall;
    logic               valid;
    logic [LOGN-1:0]    old_address_0;
    logic [LOGN-1:0]    old_address_1;
    logic [LOGN-2:0]    twiddle_index;
    logic [STAGE_W-1:0] stage;
    logic               last;
    logic               busy;
    logic               done;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    int seen [LOGN][N];

    ntt_pair_scheduler #(
        .LOGN      (LOGN),
        .STAGE_W   (STAGE_W),
        .STAGE_GAP (STAGE_GAP)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .valid         (valid),
        .old_address_0 (old_address_0),
        .old_address_1 (old_address_1),
        .twiddle_index (twiddle_index),
        .stage         (stage),
        .last          (last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_addr0"}, old_address_0, 0);
        check_eq({tag, "_addr1"}, old_address_1, 0);
        check_eq({tag, "_tw"}, twiddle_index, 0);
        check_eq({tag, "_stage"}, stage, 0);
        check_eq({tag, "_last"}, last, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    // mode 0: no stall, 1: one 3-cycle stall in stage 4, 2: random stall and start pokes
    task automatic run_transform(input int mode, input bit poke_done, input int abort_stage);
        int k, nstall, lowcnt, t0, hold_left, last_vcyc, s, j, e0, e1, etw, nbad;
        logic [LOGN-1:0]    la0, la1;
        logic [LOGN-2:0]    ltw;
        logic [STAGE_W-1:0] lst;
        bit have_last, finished, stall_used;
        k = 0; nstall = 0; lowcnt = 0; hold_left = 0; last_vcyc = 0;
        have_last = 0; finished = 0; stall_used = 0;
        la0 = '0; la1 = '0; ltw = '0; lst = '0;
        foreach (seen[a, b]) seen[a][b] = 0;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3 * TOTAL + GAPS + 100 && !finished; c++) begin
            if (done) begin
                check_eq("done_time", cyc - t0, TOTAL + 2 + nstall + GAPS);
                check_eq("pair_count", k, TOTAL);
                check_eq("valid_low_cycles", lowcnt, nstall + GAPS);
                check_eq("busy_at_done", busy, 1);
                check_eq("valid_at_done", valid, 0);
                finished = 1;
            end else begin
                check_eq("busy", busy, 1);
                if (valid) begin
                    s   = k / HALF;
                    j   = k % HALF;
                    e0  = (j / (1 << s)) * (1 << (s + 1)) + (j % (1 << s));
                    e1  = e0 + (1 << s);
                    etw = (j % (1 << s)) * (1 << (LOGN - 1 - s));
                    check_eq("addr0", old_address_0, e0);
                    check_eq("addr1", old_address_1, e1);
                    check_eq("twiddle", twiddle_index, etw);
                    check_eq("stage", stage, s);
                    check_eq("last", last, (j == HALF - 1) ? 1 : 0);
                    check_eq("parity_differs", ((^old_address_0) != (^old_address_1)) ? 1 : 0, 1);
                    if (mode == 0 && k == 0) check_eq("first_valid_latency", cyc - t0, 2);
                    if (mode == 0 && j == 0 && s > 0) check_eq("stage_gap", cyc - last_vcyc - 1, GAP_PER);
`ifndef STAGE_GAP_EN
                    if (s == 0 && j < 3) begin
                        check_eq("spot_s0_addr0", old_address_0, 2 * j);
                        check_eq("spot_s0_addr1", old_address_1, 2 * j + 1);
                        check_eq("spot_s0_tw", twiddle_index, 0);
                    end
                    if (s == 1 && j == 3) begin
                        check_eq("spot_s1j3_addr0", old_address_0, 5);
                        check_eq("spot_s1j3_addr1", old_address_1, 7);
                        check_eq("spot_s1j3_tw", twiddle_index, 256);
                    end
                    if (s == 9 && j == 0) begin
                        check_eq("spot_s9j0_addr0", old_address_0, 0);
                        check_eq("spot_s9j0_addr1", old_address_1, 512);
                        check_eq("spot_s9j0_tw", twiddle_index, 0);
                    end
                    if (s == 9 && j == 511) begin
                        check_eq("spot_s9j511_addr0", old_address_0, 511);
                        check_eq("spot_s9j511_addr1", old_address_1, 1023);
                        check_eq("spot_s9j511_tw", twiddle_index, 511);
                        check_eq("spot_s9j511_last", last, 1);
                    end
`endif
                    seen[s][old_address_0]++;
                    seen[s][old_address_1]++;
                    if (j == HALF - 1) begin
                        nbad = 0;
                        for (int a = 0; a < N; a++) if (seen[s][a] != 1) nbad++;
                        check_eq("stage_cover", nbad, 0);
                    end
                    la0 = old_address_0; la1 = old_address_1; ltw = twiddle_index; lst = stage;
                    have_last = 1;
                    last_vcyc = cyc;
                    k++;
                    if (abort_stage == s && j == 7) begin
                        start = 1'b0;
                        stall = 1'b0;
                        rst   = 1'b0;
                        #1;
                        check_all_zero("async_reset");
                        @(negedge clk);
                        rst = 1'b1;
                        finished = 1;
                    end
                end else begin
                    if (cyc >= t0 + 2 && k < TOTAL) lowcnt++;
                    if (have_last) begin
                        check_eq("hold_addr0", old_address_0, la0);
                        check_eq("hold_addr1", old_address_1, la1);
                        check_eq("hold_tw", twiddle_index, ltw);
                        check_eq("hold_stage", stage, lst);
                        check_eq("hold_last", last, 0);
                    end
                end
            end
            if (!finished) begin
                stall = 1'b0;
                start = 1'b0;
                if (mode == 1) begin
                    if (k == 4 * HALF + 100 && !stall_used) begin
                        hold_left  = 3;
                        stall_used = 1;
                    end
                    stall = (hold_left > 0);
                    if (hold_left > 0) hold_left--;
                end else if (mode == 2) begin
                    stall = GAP_BUILD ? 1'b0 : ($urandom_range(0, 3) == 0);
                    start = ($urandom_range(0, 15) == 0);
                end
                if (poke_done && k == TOTAL) start = 1'b1;
                if (stall && k < TOTAL) nstall++;
                @(negedge clk);
            end
        end
        if (!finished) check_eq("timeout", 0, 1);
        stall = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", busy, 0);

        // Start poked during the DONE cycle must be ignored.
        run_transform(0, 1'b1, -1);
        @(negedge clk);
        check_eq("busy_fall", busy, 0);
        check_eq("done_single", done, 0);
        check_eq("valid_idle", valid, 0);

        // Second call starts in the first IDLE cycle after DONE.
        run_transform(1, 1'b0, -1);
        run_transform(2, 1'b0, -1);
        @(negedge clk);
        check_eq("busy_fall_chain", busy, 0);

        run_transform(2, 1'b0, ABORT_STAGE);
        for (int i = 0; i < 4; i++) begin
            check_eq("post_abort_done", done, 0);
            check_eq("post_abort_busy", busy, 0);
            check_eq("post_abort_valid", valid, 0);
            @(negedge clk);
        end

        run_transform(0, 1'b0, -1);
        @(negedge clk);
        check_eq("busy_fall_final", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
